// File: rtl/ascon_perm_sequencer.sv
// Iterative ASCON permutation (p^a / p^b) executing UNROLL rounds per clock behind a start/done handshake.
// Define ASCON_PERM_ABORT_EN to add an abort input that cancels a running permutation.
module ascon_perm_sequencer #(
  parameter int UNROLL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
`ifdef ASCON_PERM_ABORT_EN
  input  logic        abort,
`endif
  input  logic [3:0]  nr,
  input  logic [63:0] x0_in,
  input  logic [63:0] x1_in,
  input  logic [63:0] x2_in,
  input  logic [63:0] x3_in,
  input  logic [63:0] x4_in,
  output logic [63:0] x0_out,
  output logic [63:0] x1_out,
  output logic [63:0] x2_out,
  output logic [63:0] x3_out,
  output logic [63:0] x4_out,
  output logic        busy,
  output logic        done
);

  if (UNROLL < 1 || UNROLL > 3) begin : gUnrollCheck
    $error("ascon_perm_sequencer: UNROLL must be 1, 2 or 3");
  end

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  // One full round: constant addition, bit-sliced S-box, linear diffusion. Index 0 is x0.
  function automatic logic [4:0][63:0] ascon_round(input logic [4:0][63:0] s, input logic [3:0] r);
    logic [4:0][63:0] a;
    logic [4:0][63:0] b;
    a = s;
    a[2][7:0] = a[2][7:0] ^ {4'd15 - r, r};
    a[0] = a[0] ^ a[4];
    a[4] = a[4] ^ a[3];
    a[2] = a[2] ^ a[1];
    b[0] = a[0] ^ (~a[1] & a[2]);
    b[1] = a[1] ^ (~a[2] & a[3]);
    b[2] = a[2] ^ (~a[3] & a[4]);
    b[3] = a[3] ^ (~a[4] & a[0]);
    b[4] = a[4] ^ (~a[0] & a[1]);
    b[1] = b[1] ^ b[0];
    b[0] = b[0] ^ b[4];
    b[3] = b[3] ^ b[2];
    b[2] = ~b[2];
    a[0] = b[0] ^ {b[0][18:0], b[0][63:19]} ^ {b[0][27:0], b[0][63:28]};
    a[1] = b[1] ^ {b[1][60:0], b[1][63:61]} ^ {b[1][38:0], b[1][63:39]};
    a[2] = b[2] ^ {b[2][0],    b[2][63:1]}  ^ {b[2][5:0],  b[2][63:6]};
    a[3] = b[3] ^ {b[3][9:0],  b[3][63:10]} ^ {b[3][16:0], b[3][63:17]};
    a[4] = b[4] ^ {b[4][6:0],  b[4][63:7]}  ^ {b[4][40:0], b[4][63:41]};
    return a;
  endfunction

  state_e           state_q, state_d;
  logic [4:0][63:0] x_q, x_d;
  logic [3:0]       n_q, n_d;
  logic [3:0]       i_q, i_d;
  logic [3:0]       nrClamped;
  logic [3:0]       remaining;
  logic [3:0]       step;
  logic [4:0][63:0] roundOut;
  logic             abortReq;

`ifdef ASCON_PERM_ABORT_EN
  assign abortReq = abort;
`else
  assign abortReq = 1'b0;
`endif

  assign nrClamped = (nr > 4'd12) ? 4'd12 : nr;
  assign remaining = n_q - i_q;
  assign step      = (remaining > 4'(UNROLL)) ? 4'(UNROLL) : remaining;

  // Stages beyond the remaining round count pass their input straight through.
  for (genvar j = 0; j < UNROLL; j++) begin : gStage
    logic [4:0][63:0] sIn;
    logic [4:0][63:0] sOut;
    logic [3:0]       rIdx;
    logic             active;
    if (j == 0) begin : gHead
      assign sIn = x_q;
    end else begin : gChain
      assign sIn = gStage[j-1].sOut;
    end
    assign rIdx   = 4'd12 - n_q + i_q + 4'(j);
    assign active = 4'(j) < remaining;
    assign sOut   = active ? ascon_round(sIn, rIdx) : sIn;
  end

  assign roundOut = gStage[UNROLL-1].sOut;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      n_q     <= '0;
      i_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      n_q     <= n_d;
      i_q     <= i_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    n_d     = n_q;
    i_d     = i_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = {x4_in, x3_in, x2_in, x1_in, x0_in};
          n_d     = nrClamped;
          i_d     = 4'd0;
          state_d = (nrClamped == 4'd0) ? FIN : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        x_d  = roundOut;
        i_d  = i_q + step;
        if (i_q + step == n_q) state_d = FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A cancelled permutation leaves no result behind and never reports done.
    if (abortReq && state_q != IDLE) begin
      state_d = IDLE;
      x_d     = '0;
      i_d     = 4'd0;
      done    = 1'b0;
    end
  end

  assign x0_out = x_q[0];
  assign x1_out = x_q[1];
  assign x2_out = x_q[2];
  assign x3_out = x_q[3];
  assign x4_out = x_q[4];

endmodule

// File: tb/tb_ascon_perm_sequencer.sv
// Scoreboard bench for ascon_perm_sequencer: UNROLL=1 and UNROLL=3 instances against a table-driven ASCON model.
// Covers ASCON_PERM_ABORT_EN when that macro is defined.
module tb_ascon_perm_sequencer;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  typedef struct {
    logic [319:0] st;
    int           startCyc;
    int           runCyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
`ifdef ASCON_PERM_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic        startV [2];
  logic [3:0]  nr = 4'd0;
  logic [63:0] xIn [5];
  logic [63:0] outs [2][5];
  logic        busyV [2];
  logic        doneV [2];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  exp_t        expQ [2][$];
  int          unrollOf [2] = '{1, 3};

  always #5 clk = ~clk;

  ascon_perm_sequencer #(.UNROLL(1)) dut1 (
    .clk(clk), .rst(rst), .start(startV[0]),
`ifdef ASCON_PERM_ABORT_EN
    .abort(abort),
`endif
    .nr(nr),
    .x0_in(xIn[0]), .x1_in(xIn[1]), .x2_in(xIn[2]), .x3_in(xIn[3]), .x4_in(xIn[4]),
    .x0_out(outs[0][0]), .x1_out(outs[0][1]), .x2_out(outs[0][2]),
    .x3_out(outs[0][3]), .x4_out(outs[0][4]),
    .busy(busyV[0]), .done(doneV[0]));

  ascon_perm_sequencer #(.UNROLL(3)) dut3 (
    .clk(clk), .rst(rst), .start(startV[1]),
`ifdef ASCON_PERM_ABORT_EN
    .abort(abort),
`endif
    .nr(nr),
    .x0_in(xIn[0]), .x1_in(xIn[1]), .x2_in(xIn[2]), .x3_in(xIn[3]), .x4_in(xIn[4]),
    .x0_out(outs[1][0]), .x1_out(outs[1][1]), .x2_out(outs[1][2]),
    .x3_out(outs[1][3]), .x4_out(outs[1][4]),
    .busy(busyV[1]), .done(doneV[1]));

  function automatic logic [63:0] ror64(input logic [63:0] v, input int s);
    return (v >> s) | (v << (64 - s));
  endfunction

  // Reference round: S-box applied per 5-bit column through the lookup table.
  function automatic logic [319:0] modelRound(input logic [319:0] s, input int r);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col;
    logic [4:0]  o;
    int          rotA [5] = '{19, 61, 1, 10, 7};
    int          rotB [5] = '{28, 39, 6, 17, 41};
    for (int k = 0; k < 5; k++) x[k] = s[319-64*k -: 64];
    x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
    for (int b = 0; b < 64; b++) begin
      col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
      o = SBOX[col];
      for (int k = 0; k < 5; k++) y[k][b] = o[4-k];
    end
    for (int k = 0; k < 5; k++) x[k] = y[k] ^ ror64(y[k], rotA[k]) ^ ror64(y[k], rotB[k]);
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic int clampRounds(input logic [3:0] nrv);
    return (nrv > 4'd12) ? 12 : int'(nrv);
  endfunction

  function automatic logic [319:0] modelPerm(input logic [319:0] s, input logic [3:0] nrv);
    logic [319:0] t;
    int n;
    t = s;
    n = clampRounds(nrv);
    for (int i = 0; i < n; i++) t = modelRound(t, 12 - n + i);
    return t;
  endfunction

  function automatic logic [319:0] randState();
    logic [319:0] r;
    for (int k = 0; k < 10; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [319:0] dutState(input int d);
    return {outs[d][0], outs[d][1], outs[d][2], outs[d][3], outs[d][4]};
  endfunction

  task automatic checkOutput(input string name, input logic [319:0] act, input logic [319:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  task automatic monitorDut(input int d);
    exp_t  e;
    bit    have;
    bit    expBusy;
    bit    expDone;
    string tag;
    tag = (d == 0) ? "u1" : "u3";
    have = (expQ[d].size() > 0);
    expBusy = 1'b0;
    expDone = 1'b0;
    if (have) begin
      e = expQ[d][0];
      expBusy = (cyc >= e.startCyc) && (cyc < e.startCyc + e.runCyc);
      expDone = (cyc == e.startCyc + e.runCyc);
    end
    checkOutput({tag, " busy"}, 320'(busyV[d]), 320'(expBusy));
    if (doneV[d] || expDone) begin
      checkOutput({tag, " done"}, 320'(doneV[d]), 320'(expDone));
      if (expDone) begin
        checkOutput({tag, " result"}, dutState(d), e.st);
        void'(expQ[d].pop_front());
      end
    end
  endtask

  // Monitor samples 1 time unit after each rising edge; stimulus moves on falling edges.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int d = 0; d < 2; d++) monitorDut(d);
    end
  end

  task automatic scrambleInputs();
    nr = 4'($urandom);
    for (int k = 0; k < 5; k++) xIn[k] = {$urandom, $urandom};
  endtask

  task automatic applyStimulus(input logic [3:0] nrv, input logic [319:0] s, input bit go0, input bit go1);
    exp_t e;
    nr = nrv;
    for (int k = 0; k < 5; k++) xIn[k] = s[319-64*k -: 64];
    startV[0] = go0;
    startV[1] = go1;
    for (int d = 0; d < 2; d++) begin
      if ((d == 0 && go0) || (d == 1 && go1)) begin
        e.st       = modelPerm(s, nrv);
        e.startCyc = cyc + 1;
        e.runCyc   = (clampRounds(nrv) + unrollOf[d] - 1) / unrollOf[d];
        expQ[d].push_back(e);
      end
    end
    @(negedge clk);
    startV[0] = 1'b0;
    startV[1] = 1'b0;
    scrambleInputs();
  endtask

  task automatic waitIdle();
    int k;
    k = 0;
    while ((expQ[0].size() + expQ[1].size()) > 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      total++;
      bad++;
      $display("[TB] FAIL idle wait: pending=%0d want 0", expQ[0].size() + expQ[1].size());
      expQ[0].delete();
      expQ[1].delete();
    end
    @(negedge clk);
  endtask

  task automatic checkCleared(input string why);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("u%0d %s state", unrollOf[d], why), dutState(d), '0);
      checkOutput($sformatf("u%0d %s busy", unrollOf[d], why), 320'(busyV[d]), '0);
      checkOutput($sformatf("u%0d %s done", unrollOf[d], why), 320'(doneV[d]), '0);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    expQ[0].delete();
    expQ[1].delete();
    @(posedge clk);
    #2;
    checkCleared("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [319:0] s;
    startV[0] = 1'b0;
    startV[1] = 1'b0;
    for (int k = 0; k < 5; k++) xIn[k] = '0;
    doReset();

    applyStimulus(4'd1, '0, 1'b1, 1'b1);
    waitIdle();
    for (int d = 0; d < 2; d++)
      checkOutput($sformatf("u%0d nr1 zero vector", unrollOf[d]), dutState(d),
                  {64'h000964B00000004B, 64'h0000000096000213, 64'h53FFFFFFFFFFFF90,
                   64'h12E580000000004B, 64'h0});

    applyStimulus(4'd12, {64'h80400c0600000000, 256'h0}, 1'b1, 1'b1);
    waitIdle();

    applyStimulus(4'd6, randState(), 1'b1, 1'b1);
    waitIdle();
    applyStimulus(4'd6, randState(), 1'b1, 1'b1);
    waitIdle();
    applyStimulus(4'd12, randState(), 1'b1, 1'b1);
    waitIdle();

    // Hold start high through every busy and FIN cycle; none of these may be accepted.
    applyStimulus(4'd12, randState(), 1'b1, 1'b1);
    for (int k = 1; k <= 13; k++) begin
      startV[0] = 1'b1;
      startV[1] = (k <= 5);
      scrambleInputs();
      @(negedge clk);
    end
    startV[0] = 1'b0;
    startV[1] = 1'b0;
    waitIdle();

    s = randState();
    applyStimulus(4'd0, s, 1'b1, 1'b1);
    waitIdle();
    checkOutput("u1 nr0 passthrough", dutState(0), s);
    applyStimulus(4'd15, s, 1'b1, 1'b1);
    waitIdle();

    applyStimulus(4'd12, randState(), 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    doReset();
    applyStimulus(4'd12, randState(), 1'b1, 1'b1);
    waitIdle();

`ifdef ASCON_PERM_ABORT_EN
    applyStimulus(4'd12, randState(), 1'b1, 1'b1);
    abort = 1'b1;
    expQ[0].delete();
    expQ[1].delete();
    @(posedge clk);
    #2;
    checkCleared("abort");
    @(negedge clk);
    abort = 1'b0;
    abort = 1'b1;
    applyStimulus(4'd3, randState(), 1'b1, 1'b1);
    abort = 1'b0;
    waitIdle();
`endif

    for (int t = 0; t < 20; t++) begin
      applyStimulus(4'($urandom_range(0, 15)), randState(), 1'b1, 1'b1);
      waitIdle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
